// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared constants and types for the data-side memory/MMIO responder
package mips_mem_pkg;

   localparam logic [31:0] MMIO_BASE = 32'h8000_0000;

   typedef enum logic [1:0] {
      OFF_LED   = 2'd0,
      OFF_COUNT = 2'd1,
      OFF_CMP   = 2'd2,
      OFF_STAT  = 2'd3
   } mmio_off_e;

   localparam int STAT_IRQ = 0;
   localparam int STAT_EN  = 1;

   localparam logic [31:0] CMP_RESET = 32'hFFFF_FFFF;

endpackage

// File: rtl/mips_dmem_mmio_if.sv
// rtl/mips_dmem_mmio_if.sv - core data port: memwrite/addr/writedata out, combinational readdata back
interface mips_dmem_mmio_if;

   logic        memwrite;
   logic [31:0] addr;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (output memwrite, output addr, output writedata, input readdata);
   modport slave  (input memwrite, input addr, input writedata, output readdata);

endinterface

// File: rtl/mmio_timer.sv
// rtl/mmio_timer.sv - interval timer: COUNT/CMP/STAT registers, terminal-count wrap and level IRQ flag
module mmio_timer
   import mips_mem_pkg::*;
#(
   parameter int TMR_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_count,
   input  logic             wr_cmp,
   input  logic             wr_stat,
   input  logic [31:0]      wdata,
   output logic [TMR_W-1:0] count,
   output logic [TMR_W-1:0] cmp,
   output logic             en,
   output logic             irq
);

   logic terminal;
   logic unused_wdata;

   // A COUNT write pre-empts the terminal-count step, so it also suppresses that cycle's IRQ set.
   assign terminal     = en && (count == cmp) && !wr_count;
   assign unused_wdata = ^wdata;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
         cmp   <= CMP_RESET[TMR_W-1:0];
         en    <= 1'b0;
         irq   <= 1'b0;
      end else begin
         if (wr_cmp)
            cmp <= wdata[TMR_W-1:0];
         if (wr_stat)
            en <= wdata[STAT_EN];

         if (wr_count)
            count <= wdata[TMR_W-1:0];
         else if (terminal)
            count <= '0;
         else if (en)
            count <= count + 1'b1;

         if (terminal)
            irq <= 1'b1;
         else if (wr_stat && wdata[STAT_IRQ])
            irq <= 1'b0;
      end
   end

endmodule

// File: rtl/mips_dmem_mmio.sv
// rtl/mips_dmem_mmio.sv - word RAM plus LED/timer MMIO window for the single-cycle core; timer built under DMEM_TIMER_EN
module mips_dmem_mmio
   import mips_mem_pkg::*;
#(
   parameter int RAM_AW = 6,
   parameter int LED_W  = 8,
   parameter int TMR_W  = 32
) (
   input  logic             clk,
   input  logic             reset,
   mips_dmem_mmio_if.slave  bus,
   output logic [LED_W-1:0] led,
   output logic             timer_irq
);

   logic              is_mmio;
   mmio_off_e         off;
   logic [RAM_AW-1:0] ram_idx;
   logic              wr_ram;
   logic              wr_mmio;
   logic [31:0]       ram [2**RAM_AW];
   logic [31:0]       led_ext;
   logic [31:0]       count_ext;
   logic [31:0]       cmp_ext;
   logic [31:0]       stat_ext;
   logic              unused_addr;

   assign is_mmio     = (bus.addr[31] == MMIO_BASE[31]);
   assign off         = mmio_off_e'(bus.addr[3:2]);
   assign ram_idx     = bus.addr[RAM_AW+1:2];
   assign wr_ram      = bus.memwrite && !is_mmio;
   assign wr_mmio     = bus.memwrite && is_mmio;
   assign unused_addr = ^{bus.addr[30:RAM_AW+2], bus.addr[1:0]};

   // RAM deliberately has no reset; only MMIO state is initialised.
   always_ff @(posedge clk) begin
      if (wr_ram)
         ram[ram_idx] <= bus.writedata;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         led <= '0;
      else if (wr_mmio && off == OFF_LED)
         led <= bus.writedata[LED_W-1:0];
   end

   always_comb begin
      led_ext            = '0;
      led_ext[LED_W-1:0] = led;
   end

`ifdef DMEM_TIMER_EN
   logic [TMR_W-1:0] count;
   logic [TMR_W-1:0] cmp;
   logic             en;
   logic             irq;

   mmio_timer #(.TMR_W(TMR_W)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .wr_count (wr_mmio && off == OFF_COUNT),
      .wr_cmp   (wr_mmio && off == OFF_CMP),
      .wr_stat  (wr_mmio && off == OFF_STAT),
      .wdata    (bus.writedata),
      .count    (count),
      .cmp      (cmp),
      .en       (en),
      .irq      (irq)
   );

   assign timer_irq = irq;

   always_comb begin
      count_ext              = '0;
      count_ext[TMR_W-1:0]   = count;
      cmp_ext                = '0;
      cmp_ext[TMR_W-1:0]     = cmp;
      stat_ext               = '0;
      stat_ext[STAT_IRQ]     = irq;
      stat_ext[STAT_EN]      = en;
   end
`else
   logic unused_wdata;

   assign unused_wdata = ^bus.writedata;
   assign timer_irq    = 1'b0;
   assign count_ext    = '0;
   assign cmp_ext      = '0;
   assign stat_ext     = '0;
`endif

   always_comb begin
      bus.readdata = '0;
      if (!is_mmio) begin
         bus.readdata = ram[ram_idx];
      end else begin
         case (off)
            OFF_LED:   bus.readdata = led_ext;
            OFF_COUNT: bus.readdata = count_ext;
            OFF_CMP:   bus.readdata = cmp_ext;
            OFF_STAT:  bus.readdata = stat_ext;
            default:   bus.readdata = '0;
         endcase
      end
   end

endmodule
